// File: rtl/ppm_decoder.sv
// PPM receive decoder: hunts for SOF, slices 1-of-4 PPM symbols and rebuilds frame bytes.
// Optional PPM_DEC_SYNC_EN adds a 2-flop input synchronizer ahead of edge detection.
module ppm_decoder #(
    parameter int unsigned SLOT_CLKS = 4,
    parameter int unsigned MAX_BYTES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Din,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [3:0] frame_len,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int unsigned CNT_W  = (SLOT_CLKS > 2) ? $clog2(SLOT_CLKS) : 1;
    localparam int unsigned BCNT_W = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(SLOT_CLKS / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CLKS - 1);
    localparam logic [BCNT_W-1:0] BYTES_MAX = BCNT_W'(MAX_BYTES);

    // Window patterns, bit i = level sampled in slot i
    localparam logic [3:0] PAT_SOF = 4'b1100;
    localparam logic [3:0] PAT_EOF = 4'b0011;

    typedef enum logic [1:0] {
        HUNT,
        SOF_CHK,
        DATA
    } state_e;

    logic din_s;

`ifdef PPM_DEC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], Din};
        end
    end

    assign din_s = sync_q[1];
`else
    assign din_s = Din;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        slot_q, slot_d;
    logic [2:0]        win_q, win_d;
    logic [5:0]        sh_q, sh_d;
    logic [1:0]        sym_q, sym_d;
    logic [BCNT_W-1:0] bytes_q, bytes_d;
    logic              prev_q, prev_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic [3:0]        frame_len_q, frame_len_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    logic [3:0] pat_c;
    logic       sample_c;
    logic       decide_c;
    logic       sym_ok_c;
    logic [1:0] sym_k_c;

    // Current window: slots 0..2 from history, slot 3 straight from the line
    assign pat_c    = {din_s, win_q};
    assign sample_c = (cnt_q == CNT_HALF);
    assign decide_c = sample_c && (slot_q == 2'd3);

    always_comb begin
        sym_ok_c = 1'b1;
        sym_k_c  = 2'd0;
        case (pat_c)
            4'b1110: sym_k_c = 2'd0;
            4'b1101: sym_k_c = 2'd1;
            4'b1011: sym_k_c = 2'd2;
            4'b0111: sym_k_c = 2'd3;
            default: sym_ok_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        win_d        = win_q;
        sh_d         = sh_q;
        sym_d        = sym_q;
        bytes_d      = bytes_q;
        prev_d       = din_s;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        // Slot timing free-runs once locked; no resync inside a frame
        if (state_q != HUNT) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                slot_d = slot_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (sample_c) begin
                case (slot_q)
                    2'd0:    win_d[0] = din_s;
                    2'd1:    win_d[1] = din_s;
                    2'd2:    win_d[2] = din_s;
                    default: ;
                endcase
            end
        end

        case (state_q)
            HUNT: begin
                if (prev_q && !din_s) begin
                    state_d = SOF_CHK;
                    cnt_d   = CNT_W'(1);
                    slot_d  = 2'd0;
                end
            end
            SOF_CHK: begin
                if (decide_c) begin
                    if (pat_c == PAT_SOF) begin
                        state_d = DATA;
                        bytes_d = '0;
                        sym_d   = 2'd0;
                    end else begin
                        state_d = HUNT;
                        prev_d  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (decide_c) begin
                    if (sym_ok_c) begin
                        if (bytes_q == BYTES_MAX) begin
                            frame_err_d = 1'b1;
                            state_d     = HUNT;
                            prev_d      = 1'b0;
                        end else begin
                            sh_d = {sh_q[3:0], sym_k_c};
                            if (sym_q == 2'd3) begin
                                data_out_d   = {sh_q, sym_k_c};
                                data_valid_d = 1'b1;
                                bytes_d      = bytes_q + BCNT_W'(1);
                                sym_d        = 2'd0;
                            end else begin
                                sym_d = sym_q + 2'd1;
                            end
                        end
                    end else if (pat_c == PAT_EOF && sym_q == 2'd0) begin
                        frame_len_d  = 4'(bytes_q);
                        frame_done_d = 1'b1;
                        state_d      = HUNT;
                        prev_d       = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        prev_d      = 1'b0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cnt_q        <= '0;
            slot_q       <= 2'd0;
            win_q        <= '0;
            sh_q         <= '0;
            sym_q        <= 2'd0;
            bytes_q      <= '0;
            prev_q       <= 1'b1;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_len_q  <= 4'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            win_q        <= win_d;
            sh_q         <= sh_d;
            sym_q        <= sym_d;
            bytes_q      <= bytes_d;
            prev_q       <= prev_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_len  = frame_len_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
